// File: rtl/top_level_modelsim.sv
// ---------------------------------------------------------------------------
// top_level_modelsim
//
// Single-cycle 16-bit processor datapath steered by an external control word
// on every clock. Contains an 8x16 register file, a B-operand constant mux,
// a 5-bit function-select ALU, a one-hot writeback mux, a 2**MAW x DW data
// memory, a SDEPTH-entry LIFO stack, a program counter and an instruction
// register.
//
// Ports
//   clock_50        sole clock, all state changes on the rising edge
//   clear           asynchronous active-low reset (regs, PC, IR, SP)
//   WR / MW / IR_L  register-file, data-memory and IR load enables
//   MA              B-operand select: 1 = k, 0 = R[BA]
//   Cin             ALU carry-in
//   AA, BA, DA      A-read, B-read and destination register addresses
//   FS              ALU function select
//   k               immediate / memory address (k[MAW-1:0])
//   MD              one-hot writeback select (k, PC, F, MEM[k], stack top)
//   PS              PC control: hold, +1, load k, +k
//   SS              stack control: 01 push F, 10 pop, else none
//   Cout, Z, N      carry, zero and negative flags of ALU result F
//   R0..R7          register-file contents
//
// Build option
//   REGISTERED_FLAGS_EN  when defined, Cout/Z/N are flops loaded from the ALU
//                        on every rising edge (reset to 0, one cycle behind F);
//                        when undefined they follow the current F directly.
// ---------------------------------------------------------------------------
module top_level_modelsim #(
    parameter int DW     = 16,
    parameter int SDEPTH = 16,
    parameter int MAW    = 8
) (
    input  logic          clock_50,
    input  logic          clear,
    input  logic          WR,
    input  logic          MW,
    input  logic          MA,
    input  logic          IR_L,
    input  logic          Cin,
    input  logic [2:0]    AA,
    input  logic [2:0]    BA,
    input  logic [2:0]    DA,
    input  logic [4:0]    FS,
    input  logic [DW-1:0] k,
    input  logic [4:0]    MD,
    input  logic [1:0]    PS,
    input  logic [1:0]    SS,
    output logic          Cout,
    output logic          Z,
    output logic          N,
    output logic [DW-1:0] R0,
    output logic [DW-1:0] R1,
    output logic [DW-1:0] R2,
    output logic [DW-1:0] R3,
    output logic [DW-1:0] R4,
    output logic [DW-1:0] R5,
    output logic [DW-1:0] R6,
    output logic [DW-1:0] R7
);

    // SP counts 0..SDEPTH inclusive, so it needs one bit more than the slot index.
    localparam int SPW = $clog2(SDEPTH) + 1;

    logic [DW-1:0]  regs_q [8];
    logic [DW-1:0]  regs_d [8];
    logic [DW-1:0]  pc_q, pc_d;
    logic [DW-1:0]  ir_q, ir_d;
    logic [SPW-1:0] sp_q, sp_d;

    logic [DW-1:0]  data_mem  [2**MAW];
    logic [DW-1:0]  stack_mem [SDEPTH];

    logic [DW-1:0]  a_bus, b_bus, alu_f, d_bus;
    logic           alu_cout;
    logic [DW-1:0]  mem_rd, stack_top;
    logic [SPW-1:0] sp_m1;
    logic           stack_empty, stack_full, push_ok, pop_ok;
    logic [DW:0]    cin_ext;

    // ---------------- operand selection ----------------
    assign a_bus   = regs_q[AA];
    assign b_bus   = MA ? k : regs_q[BA];
    assign cin_ext = {{DW{1'b0}}, Cin};

    // ---------------- ALU ----------------
    always_comb begin
        alu_f    = '0;
        alu_cout = 1'b0;
        case (FS)
            5'b00110: alu_f = a_bus ^ b_bus;
            5'b01000: alu_f = a_bus & b_bus;
            5'b01010: alu_f = b_bus;
            5'b01100: alu_f = a_bus;
            5'b01110: alu_f = a_bus | b_bus;
            5'b01111: alu_f = '1;
            // Arithmetic codes report the 17th bit of the sum as carry.
            5'b10001: {alu_cout, alu_f} = {1'b0, ~a_bus};
            5'b10010: {alu_cout, alu_f} = {1'b0, a_bus} + {{DW{1'b0}}, 1'b1};
            5'b10011: {alu_cout, alu_f} = {1'b0, ~a_bus} + cin_ext;
            5'b10100: {alu_cout, alu_f} = {1'b0, a_bus} + {1'b0, b_bus} + cin_ext;
            5'b10110: {alu_cout, alu_f} = {1'b0, a_bus} + {1'b0, ~b_bus} + cin_ext;
            // Shifts report the bit that falls off as carry.
            5'b11000: begin
                alu_f    = {b_bus[DW-2:0], 1'b0};
                alu_cout = b_bus[DW-1];
            end
            5'b11001: begin
                alu_f    = {1'b0, b_bus[DW-1:1]};
                alu_cout = b_bus[0];
            end
            default: begin
                alu_f    = '0;
                alu_cout = 1'b0;
            end
        endcase
    end

    // ---------------- flags ----------------
`ifdef REGISTERED_FLAGS_EN
    logic cout_q, z_q, n_q;
    logic cout_d, z_d, n_d;

    always_comb begin
        cout_d = alu_cout;
        z_d    = (alu_f == '0);
        n_d    = alu_f[DW-1];
    end

    always_ff @(posedge clock_50 or negedge clear) begin
        if (!clear) begin
            cout_q <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
        end else begin
            cout_q <= cout_d;
            z_q    <= z_d;
            n_q    <= n_d;
        end
    end

    assign Cout = cout_q;
    assign Z    = z_q;
    assign N    = n_q;
`else
    assign Cout = alu_cout;
    assign Z    = (alu_f == '0);
    assign N    = alu_f[DW-1];
`endif

    // ---------------- data memory ----------------
    // Combinational read of the old word; the write lands at the edge, so a
    // same-cycle read and write of one address sees the previous contents.
    assign mem_rd = data_mem[k[MAW-1:0]];

    always_ff @(posedge clock_50) begin
        if (clear && MW) begin
            data_mem[k[MAW-1:0]] <= alu_f;
        end
    end

    // ---------------- stack ----------------
    assign sp_m1       = sp_q - SPW'(1);
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SPW'(SDEPTH));
    assign push_ok     = (SS == 2'b01) && !stack_full;
    assign pop_ok      = (SS == 2'b10) && !stack_empty;
    // An empty stack presents 0 as its top.
    assign stack_top   = stack_empty ? '0 : stack_mem[sp_m1[SPW-2:0]];

    always_ff @(posedge clock_50) begin
        if (clear && push_ok) begin
            stack_mem[sp_q[SPW-2:0]] <= alu_f;
        end
    end

    // ---------------- writeback mux ----------------
    always_comb begin
        d_bus = '0;
        case (MD)
            5'b00001: d_bus = k;
            5'b00010: d_bus = pc_q;
            5'b00100: d_bus = alu_f;
            5'b01000: d_bus = mem_rd;
            5'b10000: d_bus = stack_top;
            default:  d_bus = '0;
        endcase
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (WR) begin
            regs_d[DA] = d_bus;
        end

        pc_d = pc_q;
        case (PS)
            2'b01:   pc_d = pc_q + DW'(1);
            2'b10:   pc_d = k;
            2'b11:   pc_d = pc_q + k;
            default: pc_d = pc_q;
        endcase

        ir_d = IR_L ? k : ir_q;

        sp_d = sp_q;
        if (push_ok) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop_ok) begin
            sp_d = sp_m1;
        end
    end

    always_ff @(posedge clock_50 or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            pc_q <= '0;
            ir_q <= '0;
            sp_q <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pc_q <= pc_d;
            ir_q <= ir_d;
            sp_q <= sp_d;
        end
    end

    assign R0 = regs_q[0];
    assign R1 = regs_q[1];
    assign R2 = regs_q[2];
    assign R3 = regs_q[3];
    assign R4 = regs_q[4];
    assign R5 = regs_q[5];
    assign R6 = regs_q[6];
    assign R7 = regs_q[7];

endmodule

// File: tb/tb_top_level_modelsim.sv
module tb_top_level_modelsim;

    logic        clock_50;
    logic        clear;
    logic        WR, MW, MA, IR_L, Cin;
    logic [2:0]  AA, BA, DA;
    logic [4:0]  FS, MD;
    logic [15:0] k;
    logic [1:0]  PS, SS;
    logic        Cout, Z, N;
    logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;

    top_level_modelsim dut (
        .clock_50(clock_50), .clear(clear),
        .WR(WR), .MW(MW), .MA(MA), .IR_L(IR_L), .Cin(Cin),
        .AA(AA), .BA(BA), .DA(DA), .FS(FS), .k(k), .MD(MD), .PS(PS), .SS(SS),
        .Cout(Cout), .Z(Z), .N(N),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_r   [8];
    logic [15:0] m_mem [256];
    logic [15:0] m_stack [$];
    logic [15:0] m_pc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] dut_regs();
        return {R0, R1, R2, R3, R4, R5, R6, R7};
    endfunction

    function automatic logic [127:0] model_regs();
        return {m_r[0], m_r[1], m_r[2], m_r[3], m_r[4], m_r[5], m_r[6], m_r[7]};
    endfunction

    // Returns {carry, F} computed with plain integer arithmetic.
    function automatic logic [16:0] model_alu(input logic [15:0] a, input logic [15:0] b,
                                              input logic ci, input logic [4:0] fs);
        int unsigned s;
        logic [15:0] na, nb;
        na = ~a;
        nb = ~b;
        case (fs)
            5'b00110: return {1'b0, a ^ b};
            5'b01000: return {1'b0, a & b};
            5'b01010: return {1'b0, b};
            5'b01100: return {1'b0, a};
            5'b01110: return {1'b0, a | b};
            5'b01111: return {1'b0, 16'hFFFF};
            5'b10001: return {1'b0, na};
            5'b10010: s = a + 1;
            5'b10011: s = na + ci;
            5'b10100: s = a + b + ci;
            5'b10110: s = a + nb + ci;
            5'b11000: s = b * 2;
            5'b11001: begin
                s = b / 2;
                return {b[0], s[15:0]};
            end
            default: return 17'h0;
        endcase
        return s[16:0];
    endfunction

    task automatic drive(input logic wr, input logic mw, input logic ma, input logic cin,
                         input logic [2:0] aa, input logic [2:0] ba, input logic [2:0] da,
                         input logic [4:0] fs, input logic [15:0] kk, input logic [4:0] md,
                         input logic [1:0] ps, input logic [1:0] ss);
        WR = wr; MW = mw; MA = ma; Cin = cin; IR_L = 1'b0;
        AA = aa; BA = ba; DA = da; FS = fs; k = kk; MD = md; PS = ps; SS = ss;
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic step(input string tag);
        logic [16:0] cf;
        logic [15:0] a, b, d;
        a  = m_r[AA];
        b  = MA ? k : m_r[BA];
        cf = model_alu(a, b, Cin, FS);
        #2;
`ifndef REGISTERED_FLAGS_EN
        chk({tag, "_flags"}, {125'h0, Cout, Z, N}, {125'h0, cf[16], cf[15:0] == 16'h0, cf[15]});
`endif
        case (MD)
            5'b00001: d = k;
            5'b00010: d = m_pc;
            5'b00100: d = cf[15:0];
            5'b01000: d = m_mem[k[7:0]];
            5'b10000: d = (m_stack.size() > 0) ? m_stack[$] : 16'h0;
            default:  d = 16'h0;
        endcase
        @(posedge clock_50);
        #1;
        if (WR) m_r[DA] = d;
        if (MW) m_mem[k[7:0]] = cf[15:0];
        case (PS)
            2'b01: m_pc = m_pc + 16'd1;
            2'b10: m_pc = k;
            2'b11: m_pc = m_pc + k;
            default: ;
        endcase
        if (SS == 2'b01 && m_stack.size() < 16) m_stack.push_back(cf[15:0]);
        else if (SS == 2'b10 && m_stack.size() > 0) void'(m_stack.pop_back());
`ifdef REGISTERED_FLAGS_EN
        chk({tag, "_flags"}, {125'h0, Cout, Z, N}, {125'h0, cf[16], cf[15:0] == 16'h0, cf[15]});
`endif
        chk({tag, "_regs"}, dut_regs(), model_regs());
        $display("step %s: R=%032h", tag, dut_regs());
    endtask

    logic [4:0] fs_list [16];

    initial begin
        fs_list = '{5'b00000, 5'b00110, 5'b01000, 5'b01010, 5'b01100, 5'b01110,
                    5'b01111, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10110,
                    5'b11000, 5'b11001, 5'b00011, 5'b10101};
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
        m_pc = 16'h0;

        drive(0, 0, 0, 0, 0, 0, 0, 5'b00000, 16'h0, 5'b00100, 2'b00, 2'b00);
        clear = 1'b1;
        #1 clear = 1'b0;
        #1;
        chk("reset_regs", dut_regs(), 128'h0);
`ifdef REGISTERED_FLAGS_EN
        chk("reset_flags", {125'h0, Cout, Z, N}, 128'h0);
`else
        chk("reset_flags", {125'h0, Cout, Z, N}, 128'h2);
`endif
        #1 clear = 1'b1;
        @(posedge clock_50);
        #1;

        // Fill memory so every word has a known value: MEM[a] = a.
        for (int i = 0; i < 256; i++) begin
            drive(0, 1, 1, 0, 0, 0, 0, 5'b01010, 16'(i), 5'b00100, 2'b00, 2'b00);
            step("minit");
        end

        // Directed program
        drive(1, 0, 1, 0, 0, 0, 0, 5'b01010, 16'h000F, 5'b00100, 2'b00, 2'b00); step("lri");
        chk("lri_r0", {112'h0, R0}, 128'h000F);
        drive(1, 0, 0, 0, 0, 0, 1, 5'b10010, 16'h0, 5'b00100, 2'b00, 2'b00); step("inc");
        chk("inc_r1", {112'h0, R1}, 128'h0010);
        drive(1, 0, 0, 0, 0, 1, 2, 5'b10100, 16'h0, 5'b00100, 2'b00, 2'b00); step("add");
        chk("add_r2", {112'h0, R2}, 128'h001F);
        drive(1, 0, 0, 1, 1, 0, 3, 5'b10110, 16'h0, 5'b00100, 2'b00, 2'b00); step("sub");
        chk("sub_r3", {112'h0, R3}, 128'h0001);
        drive(1, 0, 1, 1, 1, 0, 4, 5'b10110, 16'h0001, 5'b00100, 2'b00, 2'b00); step("dec");
        chk("dec_r4", {112'h0, R4}, 128'h000F);
        drive(1, 0, 0, 1, 0, 0, 0, 5'b10011, 16'h0, 5'b00100, 2'b00, 2'b00); step("neg");
        chk("neg_r0", {112'h0, R0}, 128'hFFF1);
        drive(0, 0, 0, 0, 0, 0, 0, 5'b11001, 16'h0, 5'b00100, 2'b00, 2'b01); step("shr_push");
        drive(0, 0, 0, 0, 0, 0, 0, 5'b11000, 16'h0, 5'b00100, 2'b00, 2'b01); step("shl_push");
        drive(1, 0, 0, 0, 0, 0, 0, 5'b00000, 16'h0, 5'b00100, 2'b00, 2'b00); step("clr");
        chk("clr_r0", {112'h0, R0}, 128'h0000);
        drive(1, 0, 0, 0, 0, 0, 0, 5'b00000, 16'h0, 5'b10000, 2'b00, 2'b10); step("pop1");
        chk("pop1_r0", {112'h0, R0}, 128'hFFE2);
        step("pop2");
        chk("pop2_r0", {112'h0, R0}, 128'h7FF8);
        drive(1, 0, 1, 0, 0, 0, 0, 5'b01010, 16'h1234, 5'b00100, 2'b00, 2'b00); step("lri2");
        drive(0, 1, 0, 0, 0, 0, 0, 5'b01100, 16'h0000, 5'b00100, 2'b00, 2'b00); step("sti");
        drive(1, 0, 0, 0, 0, 0, 1, 5'b00000, 16'h0000, 5'b01000, 2'b00, 2'b00); step("ldi");
        chk("ldi_r1", {112'h0, R1}, 128'h1234);
        drive(1, 0, 0, 0, 0, 0, 6, 5'b00000, 16'h0040, 5'b00010, 2'b10, 2'b00); step("pc_jmp");
        drive(1, 0, 0, 0, 0, 0, 7, 5'b00000, 16'h0003, 5'b00010, 2'b11, 2'b00); step("pc_rel");
        chk("pc_rel_r7", {112'h0, R7}, 128'h0040);

        // Mid-cycle reset with every enable active: nothing may be written.
        drive(1, 1, 1, 0, 0, 0, 0, 5'b01010, 16'hAB55, 5'b00100, 2'b10, 2'b01);
        #2 clear = 1'b0;
        #1 chk("rst_immediate", dut_regs(), 128'h0);
        @(posedge clock_50);
        #1 chk("rst_override", dut_regs(), 128'h0);
        clear = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 5'b00000, 16'h0, 5'b00100, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
        m_pc = 16'h0;
        m_stack.delete();
        @(posedge clock_50);
        #1;
        drive(1, 0, 0, 0, 0, 0, 5, 5'b01111, 16'h0, 5'b10000, 2'b00, 2'b10); step("pop_empty");
        chk("pop_empty_r5", {112'h0, R5}, 128'h0);
        drive(1, 0, 0, 0, 0, 0, 6, 5'b00000, 16'h0055, 5'b01000, 2'b00, 2'b00); step("mem_kept");
        chk("mem_kept_r6", {112'h0, R6}, 128'h0055);
        drive(1, 0, 0, 0, 0, 0, 7, 5'b00000, 16'h0, 5'b00010, 2'b00, 2'b00); step("pc_reset");
        chk("pc_reset_r7", {112'h0, R7}, 128'h0);

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            logic [4:0] md;
            r = $urandom_range(0, 9);
            if (r < 5) md = 5'(1 << r);
            else if (r == 9) md = 5'($urandom);
            else md = 5'b00100;
            drive(1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                  3'($urandom), 3'($urandom), 3'($urandom), fs_list[$urandom_range(0, 15)],
                  16'($urandom), md, 2'($urandom), 2'($urandom));
            IR_L = 1'($urandom);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
